mem_stage: RTL and testbench

Memory-access pipeline stage directly downstream of the execute-stage ALU. It takes the ALU result (an effective address for loads/stores, a pass-through value otherwise), runs a single-outstanding request/acknowledge transaction to data memory, and aligns and extends load data. It presents a registered result to write-back over a valid/ready handshake.

---
 rtl/mem_stage_pkg.sv | 22 ++
 rtl/mem_stage_align.sv | 26 ++
 rtl/mem_stage.sv | 131 +++++++++++++
 tb/tb_mem_stage.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: memory-op encoding, FSM states and op classification helpers.
package mem_stage_pkg;
  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_LB   = 4'd1,
    MEM_LH   = 4'd2,
    MEM_LW   = 4'd3,
    MEM_LBU  = 4'd4,
    MEM_LHU  = 4'd5,
    MEM_SB   = 4'd6,
    MEM_SH   = 4'd7,
    MEM_SW   = 4'd8
  } mem_op_t;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  function automatic logic is_store(input mem_op_t op);
    return op == MEM_SB || op == MEM_SH || op == MEM_SW;
  endfunction
  function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] off);
    return ((op == MEM_LH || op == MEM_LHU || op == MEM_SH) && off[0]) ||
           ((op == MEM_LW || op == MEM_SW) && off != 2'b00);
  endfunction
endpackage

// File: rtl/mem_stage_align.sv
// mem_stage_align: store lane steering/byte enables and load byte/halfword extraction.
module lsu_align
  import mem_stage_pkg::*;
(
  input  mem_op_t     op_i,
  input  logic [1:0]  off_i,
  input  logic [31:0] sdata_i,
  input  logic [31:0] rdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] ldata_o
);
  logic [7:0]  lbyte;
  logic [15:0] lhalf;
  assign be_o    = op_i == MEM_SB ? 4'b0001 << off_i :
                   op_i == MEM_SH ? (off_i[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign wdata_o = op_i == MEM_SB ? {4{sdata_i[7:0]}} :
                   op_i == MEM_SH ? {2{sdata_i[15:0]}} : sdata_i;
  assign lbyte   = off_i == 2'd0 ? rdata_i[7:0]   : off_i == 2'd1 ? rdata_i[15:8] :
                   off_i == 2'd2 ? rdata_i[23:16] : rdata_i[31:24];
  assign lhalf   = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];
  assign ldata_o = op_i == MEM_LB  ? {{24{lbyte[7]}}, lbyte} :
                   op_i == MEM_LBU ? {24'b0, lbyte} :
                   op_i == MEM_LH  ? {{16{lhalf[15]}}, lhalf} :
                   op_i == MEM_LHU ? {16'b0, lhalf} : rdata_i;
endmodule

// File: rtl/mem_stage.sv
// mem_stage: single-outstanding load/store stage with registered valid/ready result.
// Optional MEM_MISALIGN_TRAP_EN: misaligned accesses fault instead of issuing a request.
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  mem_op_t     in_mem_op,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [4:0]  in_rd,
  input  logic        in_reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [4:0]  out_rd,
  output logic        out_reg_write,
  output logic        out_misaligned
);
  state_t      state_q;
  mem_op_t     op_q;
  logic [1:0]  off_q;
  logic [4:0]  rd_q;
  logic        rw_q;
  logic        req_q, we_q, valid_q, owr_q, mis_q;
  logic [31:0] addr_q, wdata_q, data_q;
  logic [3:0]  be_q;
  logic [4:0]  ord_q;
  logic        accept, mis;
  logic [3:0]  be;
  logic [31:0] wdata, ldata;
  assign in_ready = state_q == IDLE && (!valid_q || out_ready);
  assign accept   = in_valid && in_ready;
`ifdef MEM_MISALIGN_TRAP_EN
  assign mis = is_misaligned(in_mem_op, in_alu_result[1:0]);
`else
  assign mis = 1'b0;
`endif
  // Idle steers the aligner from the incoming op; afterwards from the captured op.
  lsu_align u_align (
    .op_i    (state_q == IDLE ? in_mem_op : op_q),
    .off_i   (state_q == IDLE ? in_alu_result[1:0] : off_q),
    .sdata_i (in_store_data),
    .rdata_i (dmem_rdata),
    .be_o    (be),
    .wdata_o (wdata),
    .ldata_o (ldata)
  );
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state_q <= IDLE;
      op_q    <= MEM_NONE;
      off_q   <= 2'b0;
      rd_q    <= 5'b0;
      rw_q    <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 32'b0;
      be_q    <= 4'b0;
      wdata_q <= 32'b0;
      valid_q <= 1'b0;
      data_q  <= 32'b0;
      ord_q   <= 5'b0;
      owr_q   <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      if (valid_q && out_ready) valid_q <= 1'b0;
      case (state_q)
        IDLE: if (accept) begin
          if (in_mem_op == MEM_NONE || mis) begin
            valid_q <= 1'b1;
            data_q  <= in_alu_result;
            ord_q   <= in_rd;
            owr_q   <= in_reg_write && !mis;
            mis_q   <= mis;
          end else begin
            op_q    <= in_mem_op;
            off_q   <= in_alu_result[1:0];
            rd_q    <= in_rd;
            rw_q    <= in_reg_write;
            req_q   <= 1'b1;
            we_q    <= is_store(in_mem_op);
            addr_q  <= {in_alu_result[31:2], 2'b00};
            be_q    <= be;
            wdata_q <= wdata;
            state_q <= REQ;
          end
        end
        REQ: if (dmem_ack) begin
          req_q <= 1'b0;
          if (we_q) begin
            valid_q <= 1'b1;
            data_q  <= {addr_q[31:2], off_q};
            ord_q   <= rd_q;
            owr_q   <= 1'b0;
            mis_q   <= 1'b0;
            state_q <= IDLE;
          end else state_q <= RESP;
        end
        RESP: if (dmem_rvalid) begin
          valid_q <= 1'b1;
          data_q  <= ldata;
          ord_q   <= rd_q;
          owr_q   <= rw_q;
          mis_q   <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  assign dmem_req       = req_q;
  assign dmem_we        = we_q;
  assign dmem_addr      = addr_q;
  assign dmem_be        = be_q;
  assign dmem_wdata     = wdata_q;
  assign out_valid      = valid_q;
  assign out_data       = data_q;
  assign out_rd         = ord_q;
  assign out_reg_write  = owr_q;
  assign out_misaligned = mis_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed vector table plus hand sequences for stall, backpressure and reset.
module tb_mem_stage;
  import mem_stage_pkg::*;
  logic        clk = 1'b0, reset_n = 1'b0;
  logic        in_valid = 1'b0, in_ready, in_reg_write = 1'b0;
  mem_op_t     in_mem_op = MEM_NONE;
  logic [31:0] in_alu_result = '0, in_store_data = '0;
  logic [4:0]  in_rd = '0;
  logic        dmem_req, dmem_we, dmem_ack = 1'b0, dmem_rvalid = 1'b0;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata = '0;
  logic [3:0]  dmem_be;
  logic        out_valid, out_ready = 1'b1, out_reg_write, out_misaligned;
  logic [31:0] out_data;
  logic [4:0]  out_rd;
  int pass_cnt = 0, total_cnt = 0;

  mem_stage dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_mem_op(in_mem_op), .in_alu_result(in_alu_result), .in_store_data(in_store_data),
    .in_rd(in_rd), .in_reg_write(in_reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_rd(out_rd),
    .out_reg_write(out_reg_write), .out_misaligned(out_misaligned)
  );

  always #5 clk = ~clk;

  typedef struct {
    mem_op_t     op;
    logic [31:0] addr, sdata, rdata;
    logic [4:0]  rd;
    logic        rw, mis;
    logic [31:0] e_addr;
    logic [3:0]  e_be;
    logic [31:0] e_wdata, e_data;
    logic        e_rw;
  } vec_t;
  vec_t vecs[12];

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", n, act, exp);
  endtask

  task automatic drive(input mem_op_t op, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] rd, input logic rw);
    in_valid = 1'b1; in_mem_op = op; in_alu_result = a; in_store_data = d;
    in_rd = rd; in_reg_write = rw;
  endtask

  task automatic run(input vec_t v);
    logic st;
    st = v.op inside {MEM_SB, MEM_SH, MEM_SW};
    @(negedge clk);
    drive(v.op, v.addr, v.sdata, v.rd, v.rw);
    chk("in_ready_idle", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    if (v.op != MEM_NONE && !v.mis) begin
      chk("req", dmem_req, 1);
      chk("we", dmem_we, st);
      chk("addr", dmem_addr, v.e_addr);
      chk("be", dmem_be, v.e_be);
      if (st) chk("wdata", dmem_wdata, v.e_wdata);
      chk("in_ready_busy", in_ready, 0);
      dmem_ack = 1'b1;
      @(negedge clk);
      dmem_ack = 1'b0;
      if (!st) begin
        chk("resp_wait_valid", out_valid, 0);
        dmem_rvalid = 1'b1; dmem_rdata = v.rdata;
        @(negedge clk);
        dmem_rvalid = 1'b0;
      end
    end else chk("no_req", dmem_req, 0);
    chk("out_valid", out_valid, 1);
    if (!st) chk("out_data", out_data, v.e_data);
    chk("out_rd", out_rd, v.rd);
    chk("out_reg_write", out_reg_write, v.e_rw);
    chk("out_misaligned", out_misaligned, v.mis);
  endtask

  initial begin
    vecs[0]  = '{MEM_NONE, 32'h1234, 32'h0, 32'h0, 5'd5, 1'b1, 1'b0, 32'h0, 4'h0, 32'h0, 32'h1234, 1'b1};
    vecs[1]  = '{MEM_SB, 32'h103, 32'hAB, 32'h0, 5'd1, 1'b1, 1'b0, 32'h100, 4'b1000, 32'hABABABAB, 32'h0, 1'b0};
    vecs[2]  = '{MEM_LB, 32'h102, 32'h0, 32'h0080_0000, 5'd7, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'hFFFF_FF80, 1'b1};
    vecs[3]  = '{MEM_LBU, 32'h102, 32'h0, 32'h0080_0000, 5'd7, 1'b1, 1'b0, 32'h100, 4'hF, 32'h0, 32'h0000_0080, 1'b1};
    vecs[4]  = '{MEM_LH, 32'h202, 32'h0, 32'h8000_1234, 5'd8, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 32'hFFFF_8000, 1'b1};
    vecs[5]  = '{MEM_LHU, 32'h200, 32'h0, 32'h8000_9234, 5'd8, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 32'h0000_9234, 1'b1};
    vecs[6]  = '{MEM_LW, 32'h300, 32'h0, 32'hDEAD_BEEF, 5'd9, 1'b1, 1'b0, 32'h300, 4'hF, 32'h0, 32'hDEAD_BEEF, 1'b1};
    vecs[7]  = '{MEM_SH, 32'h402, 32'h1234_ABCD, 32'h0, 5'd2, 1'b1, 1'b0, 32'h400, 4'b1100, 32'hABCD_ABCD, 32'h0, 1'b0};
    vecs[8]  = '{MEM_SW, 32'h500, 32'hCAFE_F00D, 32'h0, 5'd3, 1'b1, 1'b0, 32'h500, 4'hF, 32'hCAFE_F00D, 32'h0, 1'b0};
    vecs[9]  = '{MEM_SB, 32'h101, 32'h5A, 32'h0, 5'd4, 1'b1, 1'b0, 32'h100, 4'b0010, 32'h5A5A_5A5A, 32'h0, 1'b0};
`ifdef MEM_MISALIGN_TRAP_EN
    vecs[10] = '{MEM_LH, 32'h201, 32'h0, 32'h1234_8001, 5'd10, 1'b1, 1'b1, 32'h0, 4'h0, 32'h0, 32'h201, 1'b0};
`else
    vecs[10] = '{MEM_LH, 32'h201, 32'h0, 32'h1234_8001, 5'd10, 1'b1, 1'b0, 32'h200, 4'hF, 32'h0, 32'hFFFF_8001, 1'b1};
`endif
    vecs[11] = '{MEM_NONE, 32'hFFFF_FFFF, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0, 32'hFFFF_FFFF, 1'b0};

    repeat (3) @(negedge clk);
    chk("rst_req", dmem_req, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_data", out_data, 0);
    chk("rst_be", dmem_be, 0);
    chk("rst_addr", dmem_addr, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", in_ready, 1);

    for (int i = 0; i < 12; i++) run(vecs[i]);

    // Store acked only after three stall cycles; request must hold steady.
    @(negedge clk);
    drive(MEM_SB, 32'h103, 32'hAB, 5'd6, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("stall_req", dmem_req, 1);
      chk("stall_addr", dmem_addr, 32'h100);
      chk("stall_be", dmem_be, 4'b1000);
      chk("stall_wdata", dmem_wdata, 32'hABAB_ABAB);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_valid", out_valid, 0);
      @(negedge clk);
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("stall_out_valid", out_valid, 1);
    chk("stall_out_rw", out_reg_write, 0);

    // Backpressure: result held while the next op waits, then accepted on release.
    @(negedge clk);
    out_ready = 1'b0;
    drive(MEM_NONE, 32'hAAAA, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    drive(MEM_NONE, 32'hBBBB, 32'h0, 5'd4, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_data", out_data, 32'hAAAA);
      chk("bp_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("bp_next_valid", out_valid, 1);
    chk("bp_next_data", out_data, 32'hBBBB);
    chk("bp_next_rd", out_rd, 4);

    // Reset during REQ drops the request at once; a late response is ignored.
    @(negedge clk);
    drive(MEM_LW, 32'h600, 32'h0, 5'd11, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rr_req", dmem_req, 1);
    #2 reset_n = 1'b0;
    #1 chk("rr_req_drop", dmem_req, 0);
    @(negedge clk);
    reset_n = 1'b1;
    dmem_ack = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'h1111_2222;
    @(negedge clk);
    dmem_ack = 1'b0; dmem_rvalid = 1'b0;
    chk("rr_late_valid", out_valid, 0);
    chk("rr_late_req", dmem_req, 0);
    @(negedge clk);
    chk("rr_late_valid2", out_valid, 0);
    chk("rr_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
